// File: rtl/cdr_bbpd_loop_filter.sv
// Alexander bang-bang phase detector followed by a proportional + integral
// loop filter that steers a wrapping phase-interpolator code, plus a lock detector.
`timescale 1ns/1ps
module cdr_bbpd_loop_filter #(
  parameter int PHASE_W     = 7,
  parameter int FRAC_W      = 8,
  parameter int INT_W       = 16,
  parameter int KP          = 64,
  parameter int KI          = 1,
  parameter int INT_SHIFT   = 4,
  parameter int LOCK_WIN    = 64,
  parameter int LOCK_THRESH = 8
) (
  input  logic                      data_clock,
  input  logic                      Reset,
  input  logic                      cdr_en,
  input  logic                      Dn_1,
  input  logic                      Dn,
  input  logic                      Pn,
  output logic                      up,
  output logic                      dn,
  output logic [PHASE_W-1:0]        phase_code,
  output logic signed [INT_W-1:0]   integ,
  output logic                      locked
);

  localparam int ACC_W = PHASE_W + FRAC_W;
  localparam int SUM_W = ((ACC_W > INT_W) ? ACC_W : INT_W) + 2;
  localparam int CNT_W = $clog2(LOCK_WIN) + 1;
  localparam int NET_W = $clog2(LOCK_WIN) + 2;

  localparam logic [SUM_W-1:0] KP_V     = SUM_W'(KP);
  localparam logic [INT_W+1:0] KI_V     = (INT_W + 2)'(KI);
  localparam logic [INT_W-1:0] INT_MAX  = {1'b0, {(INT_W - 1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN  = {1'b1, {(INT_W - 1){1'b0}}};
  localparam logic [CNT_W-1:0] WIN_END  = CNT_W'(LOCK_WIN);
  localparam logic [NET_W-1:0] THRESH_V = NET_W'(LOCK_THRESH);

  // ---------------------------------------------------------------------------
  // Stage 1: phase decision, always running so up/dn stay observable when frozen
  // ---------------------------------------------------------------------------
  logic transition;
  logic up_next;
  logic dn_next;

  assign transition = Dn_1 ^ Dn;
  assign up_next    = transition & (Pn == Dn);
  assign dn_next    = transition & (Pn == Dn_1);

  always_ff @(posedge data_clock or negedge Reset) begin
    if (!Reset) begin
      up <= 1'b0;
      dn <= 1'b0;
    end else begin
      up <= up_next;
      dn <= dn_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: loop filter
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]        phase_acc;
  logic [ACC_W-1:0]        phase_acc_next;
  logic signed [1:0]       pd;
  logic                    pd_active;

  assign pd        = up ? 2'sb01 : (dn ? 2'sb11 : 2'sb00);
  assign pd_active = up | dn;

  // Integral path: two guard bits make the saturation test a plain signed compare.
  logic [INT_W+1:0] integ_x;
  logic [INT_W+1:0] ki_term;
  logic [INT_W+1:0] integ_sum;
  logic [INT_W-1:0] integ_next;

  assign integ_x   = {{2{integ[INT_W-1]}}, integ};
  assign ki_term   = up ? KI_V : (dn ? -KI_V : '0);
  assign integ_sum = integ_x + ki_term;

  always_comb begin
    integ_next = integ_sum[INT_W-1:0];
    if ($signed(integ_sum) > $signed({2'b00, INT_MAX})) begin
      integ_next = INT_MAX;
    end else if ($signed(integ_sum) < $signed({2'b11, INT_MIN})) begin
      integ_next = INT_MIN;
    end
  end

  // Phase path uses the pre-update integral; overflow above ACC_W is the UI wrap.
  logic signed [INT_W-1:0] integ_shifted;
  logic [SUM_W-1:0]        prop_term;
  logic [SUM_W-1:0]        int_term;
  logic [SUM_W-1:0]        acc_sum;
  logic [SUM_W-ACC_W-1:0]  unused_acc_bits;

  assign integ_shifted   = integ >>> INT_SHIFT;
  assign prop_term       = up ? KP_V : (dn ? -KP_V : '0);
  assign int_term        = {{(SUM_W - INT_W){integ_shifted[INT_W-1]}}, integ_shifted};
  assign acc_sum         = {{(SUM_W - ACC_W){1'b0}}, phase_acc} + prop_term + int_term;
  assign phase_acc_next  = acc_sum[ACC_W-1:0];
  assign unused_acc_bits = acc_sum[SUM_W-1:ACC_W];

  assign phase_code = phase_acc[ACC_W-1:FRAC_W];

  // ---------------------------------------------------------------------------
  // Lock detector: net decision balance over windows of LOCK_WIN decisions
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [NET_W-1:0] net_sum;
  logic [NET_W-1:0] sum_inc;
  logic [NET_W-1:0] sum_abs;
  logic             window_done;
  logic             win_ok;

  assign cnt_inc     = win_cnt + 1'b1;
  assign sum_inc     = net_sum + {{(NET_W - 2){pd[1]}}, pd};
  assign sum_abs     = sum_inc[NET_W-1] ? -sum_inc : sum_inc;
  assign window_done = (cnt_inc == WIN_END);
  assign win_ok      = (sum_abs <= THRESH_V);

  always_ff @(posedge data_clock or negedge Reset) begin
    if (!Reset) begin
      phase_acc <= '0;
      integ     <= '0;
      win_cnt   <= '0;
      net_sum   <= '0;
      locked    <= 1'b0;
    end else if (cdr_en) begin
      phase_acc <= phase_acc_next;
      integ     <= integ_next;
      if (pd_active) begin
        if (window_done) begin
          locked  <= win_ok;
          win_cnt <= '0;
          net_sum <= '0;
        end else begin
          win_cnt <= cnt_inc;
          net_sum <= sum_inc;
        end
      end
    end
  end

endmodule

// File: doc/cdr_bbpd_loop_filter.md
Name: cdr_bbpd_loop_filter

Overview:
- Digital CDR stage directly downstream of the data/phase sampler.
- Takes the per-UI samples Dn_1 (previous data bit), Dn (current data bit) and Pn (edge sample between them) and forms an Alexander bang-bang phase decision.
- Runs a second-order (proportional + integral) digital loop filter on that decision.
- Outputs a wrapping phase-interpolator code and a lock indication.

Parameters:
- PHASE_W, 7, width of phase_code (2^PHASE_W interpolator steps per UI).
- FRAC_W, 8, fractional bits held below phase_code in the phase accumulator.
- INT_W, 16, signed integral accumulator width.
- KP, 64, proportional gain in phase-accumulator LSBs per decision; unsigned, must be < 2^(PHASE_W+FRAC_W-1).
- KI, 1, integral gain in integral LSBs per decision.
- INT_SHIFT, 4, arithmetic right shift applied to the integral before it is added to the phase accumulator.
- LOCK_WIN, 64, decisions per lock-evaluation window; power of two, ≥ 4.
- LOCK_THRESH, 8, maximum |net decision sum| over a window to count as locked.

Ports:
- data_clock, input, 1, recovered data clock; all state on rising edge.
- Reset, input, 1, asynchronous active-low reset.
- cdr_en, input, 1, 1 = loop running; 0 = freeze filter state and lock counters.
- Dn_1, input, 1, previous data sample.
- Dn, input, 1, current data sample.
- Pn, input, 1, edge sample between Dn_1 and Dn.
- up, output, 1, registered "clock late" decision (advance phase).
- dn, output, 1, registered "clock early" decision (retard phase).
- phase_code, output, PHASE_W, phase-interpolator control word.
- integ, output, INT_W, signed integral state (frequency-offset estimate), observability only.
- locked, output, 1, lock indication.

Behaviour:
- Reset (async assert, low): up=0, dn=0, phase_code=0, phase accumulator=0, integ=0, locked=0, window counter=0, net sum=0. Deassertion is used as-is; it is synchronised upstream.
- Stage 1 phase decision, registered on every edge regardless of cdr_en:
  - transition = Dn_1 ^ Dn.
  - up = transition & (Pn == Dn).
  - dn = transition & (Pn == Dn_1).
  - No transition gives up=dn=0.
  - up and dn are never both 1.
- Stage 2 loop filter, on the edge after stage 1, only when cdr_en=1. pd = +1 if up, -1 if dn, 0 otherwise.
  - integ_next = integ + pd*KI, saturating at +(2^(INT_W-1)-1) and -2^(INT_W-1). No wrap.
  - phase_acc (PHASE_W+FRAC_W bits, unsigned) += pd*KP + (integ >>> INT_SHIFT), sign-extended, modulo 2^(PHASE_W+FRAC_W).
    - Wrap in both directions is intended: one full wrap = one UI slip.
    - The integral term uses the pre-update integ value.
  - phase_code = phase_acc[PHASE_W+FRAC_W-1:FRAC_W].
- Latency: sample triple presented before edge k produces up/dn after edge k and a phase_code change after edge k+1.
- When pd=0 and integ≠0, phase_acc still moves by the integral term every cycle (frequency tracking).
- cdr_en=0:
  - phase_acc, integ, window counter, net sum and locked hold.
  - up/dn keep updating.
  - Re-enabling resumes from the held state with no reset of accumulators.
- Lock detector, cdr_en=1 only:
  - Every cycle with pd≠0 increments the window counter and adds pd to a signed net sum (width log2(LOCK_WIN)+2).
  - When the window counter reaches LOCK_WIN, locked is set to (|net sum| ≤ LOCK_THRESH) on that same edge, and the counter and net sum clear.
  - locked changes only at window boundaries.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first decision after deassertion is produced from the samples present at the first rising edge.

Test Plan:
- Reset check: hold Reset=0 with random Dn_1/Dn/Pn toggling -> up=dn=0, phase_code=0, integ=0, locked=0 throughout; deassert -> first up/dn one edge later.
- Decision truth table: drive (Dn_1,Dn,Pn) = (0,1,1), (0,1,0), (1,0,0), (1,1,x) -> up/dn = 1/0, 0/1, 1/0, 0/0 respectively.
- Proportional step, KP=64, FRAC_W=8, KI=0: one isolated up pulse from reset -> phase_acc = 64, phase_code stays 0; four consecutive ups -> phase_code = 1 two edges after the fourth triple.
- Integral saturation and wrap: continuous up for 40000 cycles with KI=1 -> integ saturates at 32767, never wraps negative; phase_code wraps 127 -> 0 repeatedly. Then continuous dn -> phase_code wraps 0 -> 127.
- Freeze: cdr_en=0 for 100 cycles of alternating up stimulus -> phase_code, integ and locked constant while up/dn still toggle; cdr_en=1 -> updates resume from held values.
- Lock: alternate up/dn decisions for 64 decisions -> locked=1 at the window boundary. Then 64 up-only decisions (net +64 > 8) -> locked=0 at the next boundary.
